// File: rtl/ysyx_22040729_clint_pkg.sv
// Shared CLINT address map and the byte-masked write helper used by the top
// and the per-hart register block.
package ysyx_22040729_clint_pkg;

  localparam int XLEN = 64;

  localparam logic [47:0] CLINT_BASE    = 48'h200;
  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_OFF     = 16'hbff8;

  function automatic logic [XLEN-1:0] apply_wmask(input logic [XLEN-1:0] old_val,
                                                  input logic [XLEN-1:0] wdata,
                                                  input logic [7:0]      wmask);
    logic [XLEN-1:0] res;
    res = old_val;
    for (int b = 0; b < 8; b++) begin
      if (wmask[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_22040729_clint_hart.sv
// Per-hart CLINT state: mtimecmp and msip, with the registered timer compare
// and the software interrupt derived from them.
module ysyx_22040729_clint_hart
  import ysyx_22040729_clint_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] mtime,
  input  logic            cmp_we,
  input  logic            msip_we,
  input  logic [XLEN-1:0] wdata,
  input  logic [7:0]      wmask,
  output logic [XLEN-1:0] mtimecmp,
  output logic            msip,
  output logic            tirq,
  output logic            sirq
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, which is what makes tirq compare
  // last cycle's mtime against last cycle's mtimecmp.
  // NOTE: mtimecmp resets to all-ones so no timer interrupt fires before
  // software programs it; a zero reset would assert tirq immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtimecmp <= '1;
      msip     <= 1'b0;
      tirq     <= 1'b0;
    end else begin
      if (cmp_we)             mtimecmp <= apply_wmask(mtimecmp, wdata, wmask);
      if (msip_we && wmask[0]) msip    <= wdata[0];
      tirq <= (mtime >= mtimecmp);
    end
  end

  assign sirq = msip;

endmodule

// File: rtl/ysyx_22040729_clint_mh.sv
// Multi-hart CLINT: shared prescaled mtime, per-hart mtimecmp/msip, and a
// single-cycle-latency register read port.
module ysyx_22040729_clint_mh
  import ysyx_22040729_clint_pkg::*;
#(
  parameter int NHART      = 2,
  parameter int TICK_COUNT = 'h100,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clint_req,
  input  logic [63:0]           clint_addr,
  input  logic                  clint_wen,
  input  logic [DATA_WIDTH-1:0] clint_wdata,
  input  logic [7:0]            clint_wmask,
  output logic [DATA_WIDTH-1:0] clint_rdata,
  output logic                  clint_rvalid,
  input  logic                  clint_halt,
  output logic [NHART-1:0]      clint_tirq,
  output logic [NHART-1:0]      clint_sirq
);

  localparam int PW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_COUNT - 1);

  logic [15:0]     offset;
  logic            sel, wr, rd;
  logic            mtime_hit;
  logic [NHART-1:0] msip_hit, cmp_hit, msip_q;
  logic [XLEN-1:0] mtimecmp_q [NHART];
  logic [XLEN-1:0] mtime_q;
  logic [PW-1:0]   presc_q;
  logic            tick;
  logic [XLEN-1:0] rd_mux;

  assign offset    = clint_addr[15:0];
  assign sel       = clint_req && (clint_addr[63:16] == CLINT_BASE);
  assign wr        = sel && clint_wen;
  assign rd        = sel && !clint_wen;
  assign mtime_hit = (offset == MTIME_OFF);
  assign tick      = !clint_halt && (presc_q == TICK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      if (!clint_halt) presc_q <= tick ? '0 : presc_q + PW'(1);
      // A software write wins over a coinciding tick; the prescaler still wraps.
      if (wr && mtime_hit) mtime_q <= apply_wmask(mtime_q, clint_wdata, clint_wmask);
      else if (tick)       mtime_q <= mtime_q + 64'd1;
    end
  end

  for (genvar g = 0; g < NHART; g++) begin : g_hart
    assign msip_hit[g] = (offset == MSIP_BASE + 16'(4 * g));
    assign cmp_hit[g]  = (offset == MTIMECMP_BASE + 16'(8 * g));

    ysyx_22040729_clint_hart u_hart (
      .clk      (clk),
      .rst      (rst),
      .mtime    (mtime_q),
      .cmp_we   (wr && cmp_hit[g]),
      .msip_we  (wr && msip_hit[g]),
      .wdata    (clint_wdata),
      .wmask    (clint_wmask),
      .mtimecmp (mtimecmp_q[g]),
      .msip     (msip_q[g]),
      .tirq     (clint_tirq[g]),
      .sirq     (clint_sirq[g])
    );
  end

  // NOTE: rd_mux is defaulted before any conditional assignment so the
  // combinational block can never infer a latch for unmapped offsets.
  always_comb begin
    rd_mux = '0;
    if (mtime_hit) rd_mux = mtime_q;
    for (int i = 0; i < NHART; i++) begin
      if (msip_hit[i]) rd_mux = {63'b0, msip_q[i]};
      if (cmp_hit[i])  rd_mux = mtimecmp_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clint_rvalid <= 1'b0;
      clint_rdata  <= '0;
    end else begin
      clint_rvalid <= rd;
      clint_rdata  <= rd ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_ysyx_22040729_clint_mh.sv
// Directed bench for the multi-hart CLINT with a fast prescaler (TICK_COUNT=4).
module tb_ysyx_22040729_clint_mh;

  localparam logic [63:0] A_MSIP0 = 64'h0200_0000;
  localparam logic [63:0] A_MSIP1 = 64'h0200_0004;
  localparam logic [63:0] A_CMP0  = 64'h0200_4000;
  localparam logic [63:0] A_CMP1  = 64'h0200_4008;
  localparam logic [63:0] A_CMP2  = 64'h0200_4010;
  localparam logic [63:0] A_MTIME = 64'h0200_bff8;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk, rst;
  logic        clint_req, clint_wen, clint_halt, clint_rvalid;
  logic [63:0] clint_addr, clint_wdata, clint_rdata;
  logic [7:0]  clint_wmask;
  logic [1:0]  clint_tirq, clint_sirq;

  int checks   = 0;
  int failures = 0;

  ysyx_22040729_clint_mh #(.NHART(2), .TICK_COUNT(4), .DATA_WIDTH(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .clint_req    (clint_req),
    .clint_addr   (clint_addr),
    .clint_wen    (clint_wen),
    .clint_wdata  (clint_wdata),
    .clint_wmask  (clint_wmask),
    .clint_rdata  (clint_rdata),
    .clint_rvalid (clint_rvalid),
    .clint_halt   (clint_halt),
    .clint_tirq   (clint_tirq),
    .clint_sirq   (clint_sirq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Leaves the caller at a negedge right after reset release (no posedge yet).
  task automatic do_reset();
    clint_req  = 1'b0;
    clint_wen  = 1'b0;
    clint_halt = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic bus_write(input logic [63:0] addr, input logic [63:0] data,
                           input logic [7:0] mask);
    clint_req = 1'b1; clint_wen = 1'b1;
    clint_addr = addr; clint_wdata = data; clint_wmask = mask;
    @(negedge clk);
    clint_req = 1'b0; clint_wen = 1'b0; clint_wmask = 8'h00;
  endtask

  task automatic bus_read(input logic [63:0] addr, output logic [63:0] data);
    clint_req = 1'b1; clint_wen = 1'b0; clint_addr = addr;
    @(negedge clk);
    clint_req = 1'b0;
    check("rvalid", {63'b0, clint_rvalid}, 64'd1);
    data = clint_rdata;
  endtask

  logic [63:0] d;

  initial begin
    clint_addr = '0; clint_wdata = '0; clint_wmask = '0;
    clint_req = 1'b0; clint_wen = 1'b0; clint_halt = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("rst_rvalid", {63'b0, clint_rvalid}, 64'd0);
    check("rst_rdata",  clint_rdata, 64'd0);
    check("rst_tirq",   {62'b0, clint_tirq}, 64'd0);
    check("rst_sirq",   {62'b0, clint_sirq}, 64'd0);

    // Tick timing: mtime=1 after 4 cycles, 5 after 20.
    do_reset();
    repeat (4) @(negedge clk);
    bus_read(A_MTIME, d); check("mtime_4", d, 64'd1);
    @(negedge clk);
    check("idle_rvalid", {63'b0, clint_rvalid}, 64'd0);
    check("idle_rdata",  clint_rdata, 64'd0);
    repeat (14) @(negedge clk);
    bus_read(A_MTIME, d); check("mtime_20", d, 64'd5);

    // Compare boundary on hart 1.
    do_reset();
    bus_write(A_CMP1, 64'd3, 8'hFF);
    repeat (11) @(negedge clk);
    check("tirq_pre", {62'b0, clint_tirq}, 64'd0);
    @(negedge clk);
    check("tirq_hit", {62'b0, clint_tirq}, 64'd2);

    // Masked writes and unmapped offsets.
    do_reset();
    bus_write(A_CMP0, ONES, 8'hFF);
    bus_write(A_CMP0, 64'h12, 8'h01);
    bus_read(A_CMP0, d); check("cmp0_mask_lo", d, 64'hFFFF_FFFF_FFFF_FF12);
    bus_write(A_CMP0, 64'hAABB_CCDD_0000_0000, 8'hF0);
    bus_read(A_CMP0, d); check("cmp0_mask_hi", d, 64'hAABB_CCDD_FFFF_FF12);
    bus_read(A_CMP1, d); check("cmp1_untouched", d, ONES);
    bus_write(A_CMP2, 64'd7, 8'hFF);
    bus_read(A_CMP2, d); check("cmp2_unmapped", d, 64'd0);
    bus_read(64'h0200_1234, d); check("unmapped_rd", d, 64'd0);

    // Software interrupt.
    bus_write(A_MSIP1, 64'd1, 8'h01);
    check("sirq_set", {62'b0, clint_sirq}, 64'd2);
    bus_read(A_MSIP0, d); check("msip0_rd", d, 64'd0);
    bus_read(A_MSIP1, d); check("msip1_rd", d, 64'd1);
    bus_write(A_MSIP1, 64'd0, 8'h00);
    check("sirq_nomask", {62'b0, clint_sirq}, 64'd2);
    bus_write(A_MSIP1, 64'hFE, 8'h01);
    check("sirq_clr", {62'b0, clint_sirq}, 64'd0);

    // Write/tick collision then halt.
    do_reset();
    repeat (3) @(negedge clk);
    bus_write(A_MTIME, 64'h100, 8'hFF);
    bus_read(A_MTIME, d); check("mtime_collide", d, 64'h100);
    repeat (3) @(negedge clk);
    bus_read(A_MTIME, d); check("mtime_after_tick", d, 64'h101);
    clint_halt = 1'b1;
    repeat (50) @(negedge clk);
    bus_read(A_MTIME, d); check("mtime_halt", d, 64'h101);
    bus_write(A_MTIME, 64'h55, 8'hFF);
    bus_read(A_MTIME, d); check("mtime_halt_wr", d, 64'h55);
    clint_halt = 1'b0;

    // Reset asserted mid-read.
    do_reset();
    bus_write(A_CMP0, 64'd0, 8'hFF);
    @(negedge clk);
    check("tirq0_on", {62'b0, clint_tirq}, 64'd1);
    clint_req = 1'b1; clint_wen = 1'b0; clint_addr = A_MTIME;
    @(posedge clk); #1;
    check("rvalid_pre_rst", {63'b0, clint_rvalid}, 64'd1);
    rst = 1'b0;
    #1;
    check("rst_mid_rvalid", {63'b0, clint_rvalid}, 64'd0);
    check("rst_mid_tirq",   {62'b0, clint_tirq}, 64'd0);
    clint_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_rvalid", {63'b0, clint_rvalid}, 64'd0);
    bus_read(A_CMP0, d); check("post_rst_cmp0", d, ONES);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22040729_clint_mh.md
YSYX_22040729_CLINT_MH -- requirements
Module: ysyx_22040729_clint_mh

Interface
REQ-001 SHALL have parameter NHART, default 2, range 1..8: number of harts served.
REQ-002 SHALL have parameter TICK_COUNT, default 'h100: number of clk cycles per mtime increment.
REQ-003 SHALL have parameter DATA_WIDTH, default 64: data bus width; only 64 is supported.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port clint_req, input, 1: access request, qualified with clint_addr.
REQ-007 SHALL have port clint_addr, input, 64: byte address.
REQ-008 SHALL have port clint_wen, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port clint_wdata, input, 64: write data.
REQ-010 SHALL have port clint_wmask, input, 8: byte write strobes.
REQ-011 SHALL have port clint_rdata, output, 64: read data.
REQ-012 SHALL have port clint_rvalid, output, 1: read data valid.
REQ-013 SHALL have port clint_halt, input, 1: freezes mtime and the prescaler (debug).
REQ-014 SHALL have port clint_tirq, output, NHART: per-hart timer interrupt.
REQ-015 SHALL have port clint_sirq, output, NHART: per-hart software interrupt.

Function
REQ-016 SHALL decode as selected when clint_req is 1 and clint_addr[63:16] equals 'h200.
REQ-017 SHALL map the registers at these offsets: msip[h] at 0x0000+4h, 32-bit, only bit 0 implemented; mtimecmp[h] at 0x4000+8h, 64-bit; mtime at 0xbff8, 64-bit.
REQ-018 SHALL ignore writes to unmapped offsets and to hart indices >= NHART, and return 0 on reads of them.
REQ-019 SHALL, on a write, update only the bytes whose clint_wmask bit is 1; for msip, only clint_wmask[0] and wdata bit 0 take effect.
REQ-020 SHALL give reads a latency of exactly 1 cycle: clint_rvalid=1 and clint_rdata valid in the cycle after the request, and clint_rdata=0 whenever clint_rvalid=0.
REQ-021 SHALL return from a read the register value as it was before any same-cycle hardware update.
REQ-022 SHALL increment the prescaler counter each cycle while clint_halt=0, and on reaching TICK_COUNT-1 wrap it to 0 and increment mtime by 1.
REQ-023 SHALL, while clint_halt=1, hold both the prescaler and mtime; software writes to mtime are still accepted.
REQ-024 SHALL, when a software write to mtime coincides with a tick, apply the write value (not +1) and clear the prescaler.
REQ-025 SHALL let mtime wrap from 2^64-1 to 0 without flagging.
REQ-026 SHALL drive clint_tirq[h] as a register: clint_tirq[h] = (mtime >= mtimecmp[h]), unsigned, using values from the previous cycle.
REQ-027 SHALL drive clint_sirq[h] directly from msip[h].

Reset
REQ-028 SHALL, while rst=0, force mtime=0, prescaler=0, msip=0, mtimecmp[h]=all-ones, clint_tirq=0, clint_sirq=0, clint_rvalid=0 and clint_rdata=0.
REQ-029 SHALL discard any access in flight when reset is asserted; no clint_rvalid appears after reset is released.

Structure
REQ-030 SHALL place the offset constants (MSIP_BASE, MTIMECMP_BASE, MTIME_OFF) and the CLINT base 'h200 in a shared package.
REQ-031 SHALL implement one sub-module, ysyx_22040729_clint_hart: holds mtimecmp and msip for one hart, applies the masked write, and produces that hart's clint_tirq and clint_sirq; it is instantiated NHART times.
REQ-032 SHALL use the existing Reg primitive, or equivalent flops with asynchronous active-low reset.

Verification
REQ-033 SHALL cover tick timing: with TICK_COUNT=4 and halt=0 from reset -> mtime reads 1 after 4 cycles and 5 after 20 cycles.
REQ-034 SHALL cover the compare boundary: write mtimecmp[1]=3 -> clint_tirq[1] rises one cycle after mtime reaches 3; clint_tirq[0] stays 0.
REQ-035 SHALL cover the masked write: mtimecmp[0]=0xFFFF_FFFF_FFFF_FFFF, then write wdata=0x12 with wmask=8'h01 -> mtimecmp[0] reads 0xFFFF_FFFF_FFFF_FF12.
REQ-036 SHALL cover msip: write 1 to 0x0200_0004 -> clint_sirq=2'b10 next cycle; reading 0x0200_0000 returns 0.
REQ-037 SHALL cover write/tick collision and halt: write mtime=0x100 on the tick cycle -> next read returns 0x100; then halt=1 for 50 cycles -> mtime unchanged.
REQ-038 SHALL cover reset: rst=0 asserted mid-read -> clint_rvalid=0 and clint_tirq=0 immediately, and mtimecmp reads all-ones after release.
